// File: rtl/mem_responder.sv
// mem_responder
//   Word-addressed memory target with a configurable wait-state FSM and a
//   ready/err handshake. A request is accepted in IDLE, optionally held for
//   WAIT_STATES cycles in WAIT, and completed with a one-cycle RESP in which
//   ready is pulsed and (for reads) data_bus is driven.
// Ports
//   clk       in     system clock, rising edge
//   rst       in     asynchronous reset, active-low
//   read_en   in     read request, held until ready
//   write_en  in     write request, held until ready
//   address   in     word address [ADDR_W-1:0]
//   data_bus  inout  write data in / read data out, Z when not driving
//   ready     out    one-cycle pulse, transaction complete
//   busy      out    high from accept until ready (inclusive)
//   err       out    one-cycle pulse, read_en and write_en both high in IDLE
module mem_responder #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_s;
  logic [ADDR_W-1:0]   lat_addr_r;
  logic [DATA_W-1:0]   lat_data_r;
  logic                lat_wr_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DATA_W-1:0]   rd_data_r;
  logic                drive_r;
  logic                ready_r;
  logic                busy_r;
  logic                err_r;

  logic                accept_s;
  logic                illegal_s;
  logic                enter_resp_s;
  logic                commit_s;
  logic [ADDR_W-1:0]   tgt_addr_s;
  logic [DATA_W-1:0]   tgt_data_s;
  logic                tgt_wr_s;

  // Next-state and counter logic of the wait-state FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    illegal_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (read_en ^ write_en) begin
          accept_s = 1'b1;
          cnt_s    = 4'd0;
          state_s  = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end else if (read_en & write_en) begin
          illegal_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_s = cnt_r + 4'd1;
        // A dropped request wins over reaching the last wait cycle.
        if (!read_en && !write_en) begin
          state_s = S_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_s = S_RESP;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_RESP: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Transaction target: with zero wait states RESP is entered on the accept
  // edge itself, before the latches hold anything, so use the live inputs.
  always_comb begin
    if (state_r == S_IDLE) begin
      tgt_addr_s = address;
      tgt_data_s = data_bus;
      tgt_wr_s   = write_en;
    end else begin
      tgt_addr_s = lat_addr_r;
      tgt_data_s = lat_data_r;
      tgt_wr_s   = lat_wr_r;
    end
    enter_resp_s = (state_s == S_RESP) && (state_r != S_RESP);
    commit_s     = enter_resp_s && tgt_wr_s;
  end

  // State, request latches and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= 4'd0;
      lat_addr_r <= {ADDR_W{1'b0}};
      lat_data_r <= {DATA_W{1'b0}};
      lat_wr_r   <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
      drive_r    <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        lat_addr_r <= address;
        lat_data_r <= data_bus;
        lat_wr_r   <= write_en;
      end
      if (enter_resp_s && !tgt_wr_s) begin
        rd_data_r <= mem_r[tgt_addr_s];
      end
      drive_r <= enter_resp_s && !tgt_wr_s;
      ready_r <= (state_s == S_RESP);
      busy_r  <= (state_s != S_IDLE);
      err_r   <= illegal_s;
    end
  end

  // Storage array; contents survive reset, writes are gated while in reset.
  always_ff @(posedge clk) begin
    if (rst && commit_s) begin
      mem_r[tgt_addr_s] <= tgt_data_s;
    end
  end

  assign data_bus = drive_r ? rd_data_r : {DATA_W{1'bz}};
  assign ready    = ready_r;
  assign busy     = busy_r;
  assign err      = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Three responders (WAIT_STATES 0, 1, 3) exercised by directed and random
//   transactions. A transaction-level model (word array plus the rule that
//   ready appears WAIT_STATES+1 cycles after the accept edge) supplies every
//   expected value.
module tb_mem_responder;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en    [N];
  logic       wr_en    [N];
  logic [4:0] addr     [N];
  logic       drv_en   [N];
  logic [7:0] drv_data [N];
  logic [7:0] bus_obs  [N];
  logic       rdy_obs  [N];
  logic       busy_obs [N];
  logic       err_obs  [N];
  logic [7:0] model_mem [N][32];
  int         n_cmp = 0;
  int         n_mis = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    wire [7:0] bus;
    logic      rdy;
    logic      bsy;
    logic      er;
    mem_responder #(
      .ADDR_W(5),
      .DATA_W(8),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .read_en(rd_en[g]),
      .write_en(wr_en[g]),
      .address(addr[g]),
      .data_bus(bus),
      .ready(rdy),
      .busy(bsy),
      .err(er)
    );
    assign bus         = drv_en[g] ? drv_data[g] : 8'hzz;
    assign bus_obs[g]  = bus;
    assign rdy_obs[g]  = rdy;
    assign busy_obs[g] = bsy;
    assign err_obs[g]  = er;
  end

  function automatic int ws_of(int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction on instance i. op: 0 read, 1 write, 2 illegal (both).
  // Entered just after a negedge with the responder idle; returns after the
  // negedge of the ready cycle (or of the last checked idle cycle).
  task automatic txn(int i, int op, logic [4:0] a, logic [7:0] d, int drop_at, bit hold);
    int    ws;
    string p;
    ws = ws_of(i);
    p  = $sformatf("ws%0d op%0d a%0h", ws, op, a);
    check_eq({p, " idle busy"}, 32'(busy_obs[i]), 32'd0);
    check_eq({p, " idle ready"}, 32'(rdy_obs[i]), 32'd0);
    addr[i]     = a;
    rd_en[i]    = (op != 1);
    wr_en[i]    = (op != 0);
    drv_en[i]   = (op != 0);
    drv_data[i] = d;
    @(posedge clk);
    @(negedge clk);
    if (op == 2) begin
      check_eq({p, " err pulse"}, 32'(err_obs[i]), 32'd1);
      check_eq({p, " err ready"}, 32'(rdy_obs[i]), 32'd0);
      check_eq({p, " err busy"}, 32'(busy_obs[i]), 32'd0);
      check_eq({p, " err bus"}, 32'(bus_obs[i]), 32'(d));
      rd_en[i] = 1'b0;
      wr_en[i] = 1'b0;
      @(negedge clk);
      check_eq({p, " err end"}, 32'(err_obs[i]), 32'd0);
      check_eq({p, " err end ready"}, 32'(rdy_obs[i]), 32'd0);
      return;
    end
    for (int c = 1; c <= ws + 1; c++) begin
      if (c > 1) @(negedge clk);
      check_eq($sformatf("%s c%0d ready", p, c), 32'(rdy_obs[i]), (c == ws + 1) ? 32'd1 : 32'd0);
      check_eq($sformatf("%s c%0d busy", p, c), 32'(busy_obs[i]), 32'd1);
      check_eq($sformatf("%s c%0d err", p, c), 32'(err_obs[i]), 32'd0);
      if (op == 1) begin
        check_eq($sformatf("%s c%0d wbus", p, c), 32'(bus_obs[i]), 32'(drv_data[i]));
      end
      if (c == 1) begin
        addr[i]     = 5'($urandom);
        drv_data[i] = 8'h00;
      end
      if (c == ws + 1) begin
        if (op == 0) begin
          check_eq({p, " rdata"}, 32'(bus_obs[i]), 32'(model_mem[i][a]));
        end else begin
          model_mem[i][a] = d;
        end
        if (!hold) begin
          rd_en[i] = 1'b0;
          wr_en[i] = 1'b0;
        end
        addr[i] = a;
      end else if (c == drop_at) begin
        rd_en[i] = 1'b0;
        wr_en[i] = 1'b0;
        @(negedge clk);
        check_eq({p, " abort busy"}, 32'(busy_obs[i]), 32'd0);
        check_eq({p, " abort ready"}, 32'(rdy_obs[i]), 32'd0);
        @(negedge clk);
        check_eq({p, " abort ready2"}, 32'(rdy_obs[i]), 32'd0);
        return;
      end
    end
  endtask

  task automatic preload(int i);
    logic [7:0] d;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      d = 8'($urandom);
      if (d == 8'h11 || d == 8'h5A) d = ~d;
      txn(i, 1, 5'(a), d, 0, 1'b0);
    end
  endtask

  task automatic rand_run(int i, int n);
    int         ws;
    int         op;
    int         r;
    bit         hold;
    bit         hold_nx;
    logic [4:0] a;
    logic [7:0] d;
    ws   = ws_of(i);
    hold = 1'b0;
    op   = 0;
    a    = 5'd0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      d = 8'($urandom);
      if (!hold) begin
        r = int'($urandom_range(0, 99));
        if (r < 45)      op = 0;
        else if (r < 80) op = 1;
        else if (r < 88) op = 2;
        else             op = (ws > 0) ? 3 : 1;
        a = 5'($urandom);
      end else begin
        op = 0;
      end
      hold_nx = (op == 0) && (t < n - 1) && ($urandom_range(0, 3) == 0);
      if (op == 3) txn(i, 1, a, d, int'($urandom_range(1, ws)), 1'b0);
      else         txn(i, op, a, d, 0, hold_nx);
      hold = hold_nx;
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd_en[i]    = 1'b0;
      wr_en[i]    = 1'b0;
      addr[i]     = 5'd0;
      drv_en[i]   = 1'b1;
      drv_data[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("ws%0d rst ready", ws_of(i)), 32'(rdy_obs[i]), 32'd0);
      check_eq($sformatf("ws%0d rst busy", ws_of(i)), 32'(busy_obs[i]), 32'd0);
      check_eq($sformatf("ws%0d rst err", ws_of(i)), 32'(err_obs[i]), 32'd0);
      check_eq($sformatf("ws%0d rst bus", ws_of(i)), 32'(bus_obs[i]), 32'd0);
    end
    rst = 1'b1;

    fork
      preload(0);
      preload(1);
      preload(2);
    join

    // Write then read back 0x1F with one wait state.
    @(negedge clk); txn(1, 1, 5'h1F, 8'hA5, 0, 1'b0);
    @(negedge clk); txn(1, 0, 5'h1F, 8'h00, 0, 1'b0);
    // Read latency with zero and three wait states.
    @(negedge clk); txn(0, 0, 5'h0A, 8'h00, 0, 1'b0);
    @(negedge clk); txn(2, 0, 5'h0A, 8'h00, 0, 1'b0);
    // Illegal request, then confirm the word was not touched.
    @(negedge clk); txn(0, 2, 5'h02, 8'h3C, 0, 1'b0);
    @(negedge clk); txn(0, 0, 5'h02, 8'h00, 0, 1'b0);
    // Aborted write keeps the old contents.
    @(negedge clk); txn(2, 1, 5'h04, 8'h11, 2, 1'b0);
    @(negedge clk); txn(2, 0, 5'h04, 8'h00, 0, 1'b0);
    // Held read: second transaction after one idle cycle.
    @(negedge clk); txn(1, 0, 5'h07, 8'h00, 0, 1'b1);
    @(negedge clk); txn(1, 0, 5'h07, 8'h00, 0, 1'b0);

    // Reset in the middle of a write wait period drops the write.
    @(negedge clk);
    addr[2]     = 5'h03;
    wr_en[2]    = 1'b1;
    drv_en[2]   = 1'b1;
    drv_data[2] = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst-mid pre busy", 32'(busy_obs[2]), 32'd1);
    drv_data[2] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst-mid ready", 32'(rdy_obs[2]), 32'd0);
    check_eq("rst-mid busy", 32'(busy_obs[2]), 32'd0);
    check_eq("rst-mid err", 32'(err_obs[2]), 32'd0);
    check_eq("rst-mid bus", 32'(bus_obs[2]), 32'd0);
    wr_en[2] = 1'b0;
    @(negedge clk);
    check_eq("rst-mid held busy", 32'(busy_obs[2]), 32'd0);
    check_eq("rst-mid held ready", 32'(rdy_obs[2]), 32'd0);
    rst = 1'b1;
    @(negedge clk); txn(2, 0, 5'h03, 8'h00, 0, 1'b0);

    fork
      rand_run(0, 40);
      rand_run(1, 40);
      rand_run(2, 40);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
